cpu_player: RTL and testbench
=============================

# cpu_player

Computer opponent for the tug-of-war game. It consumes the 10-bit pseudo-random word from the upstream LFSR every sampling tick and compares it against a switch-set difficulty threshold. It then emits button-press pulses that look like a debounced human press: exactly one cycle high, followed by a mandatory release gap. Its output feeds the playfield's player-2 press input in place of a KEY edge detector.

## Interface

Parameters:

- WIDTH, 10: width of rand_in; the threshold is WIDTH-1 bits.
- HOLDOFF, 4: number of forced-low cycles after each press pulse; must be ≥1.
- SAMPLE_DIV, 1: decision made once every SAMPLE_DIV enabled cycles; must be ≥1.

Ports:

- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- enable  in  1  game active; low freezes the block in IDLE.
- rand_in  in  WIDTH  pseudo-random word, sampled directly from the LFSR register output.
- threshold  in  WIDTH-1  difficulty from SW[8:0].
- press  out  1  registered one-cycle press pulse.
- busy  out  1  high while in PRESS or HOLDOFF.
- press_count  out  8  number of pulses issued; saturates at 255.

## Operation

- want = ({1'b0, threshold} > rand_in): unsigned, strict compare at WIDTH bits.
  - threshold = 0 never presses.
  - Equality never presses.
- Divider div_cnt counts 0..SAMPLE_DIV-1 and wraps.
  - It advances only while enable = 1.
  - It is forced to 0 in any cycle with enable = 0.
  - tick = enable && (div_cnt == SAMPLE_DIV-1).
- States:
  - IDLE: on tick && want, go to PRESS; otherwise stay.
  - PRESS: press = 1 for exactly this one cycle. Load hold_cnt = HOLDOFF-1 and go to HOLDOFF.
  - HOLDOFF: press = 0. Decrement hold_cnt; when hold_cnt == 0, go to IDLE.
- In IDLE, ticks are evaluated; in PRESS and HOLDOFF they are ignored, not queued.
- enable = 0 in any state forces IDLE at the next edge and clears hold_cnt.
  - A pulse already on press in that cycle is not retracted.
- press_count increments on every cycle with press = 1 and holds at 255.
  - Only reset clears it; enable does not affect it.
- busy = (state != IDLE), decoded from the state register.

## Timing

- Reset values: state IDLE, press 0, busy 0, press_count 0, div_cnt 0, hold_cnt 0.
- Reset has priority over enable and all other inputs. Reset asserted mid-PRESS or mid-HOLDOFF drops every output to 0 at the next edge.
- Latency: a tick cycle with want = 1 in IDLE gives press = 1 in the following cycle.
- With want held at 1 and SAMPLE_DIV = 1, the pulse period is HOLDOFF+2 cycles: 1 PRESS, HOLDOFF cycles of HOLDOFF, 1 IDLE evaluation cycle.
- Two press pulses are never adjacent; there are always at least HOLDOFF low cycles between them.
- rand_in and threshold are used only in IDLE tick cycles. Changes at any other time have no effect.
- After enable rises at cycle e, the first tick is at e+SAMPLE_DIV-1. The earliest press is therefore at e+SAMPLE_DIV.
- No combinational path from inputs to outputs.

## Test plan

- Reset, then enable = 1, threshold = 0, rand_in = 0 for 20 cycles -> press never 1, busy 0, press_count 0.
- Defaults, threshold = 511, rand_in = 10 held for 30 cycles from enable rising at cycle 0:
  - press high at cycles 1, 7, 13, 19, 25;
  - busy high at cycles 1-5, 7-11, …;
  - press_count = 5.
- Strict compare, threshold = 511:
  - rand_in = 600 -> no press;
  - rand_in = 511 -> no press;
  - rand_in = 510 -> press next cycle.
- enable dropped on the 2nd HOLDOFF cycle -> busy 0 next cycle. Re-enable with want = 1 at cycle r -> press at r+1, a full fresh pulse.
- Reset asserted for one cycle in PRESS -> next cycle press = 0, busy = 0, press_count = 0. Run 300 press pulses -> press_count reads 255 and stays there.
- Instance with SAMPLE_DIV = 4, HOLDOFF = 1, want held, enable rising at cycle 0 -> press at cycles 4, 8, 12, with no pulses between.

Source files
------------

// File: rtl/cpu_player.sv
// rtl/cpu_player.sv - computer opponent issuing debounced-looking one-cycle press pulses
// Compares the LFSR word against a difficulty threshold on each sampling tick.
module cpu_player #(
  parameter int WIDTH      = 10,
  parameter int HOLDOFF    = 4,
  parameter int SAMPLE_DIV = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] rand_in,
  input  logic [WIDTH-2:0] threshold,
  output logic             press,
  output logic             busy,
  output logic [7:0]       press_count
);

  localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [DW-1:0] DIV_LAST  = DW'(SAMPLE_DIV - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PRESS = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]    state;
  logic [DW-1:0] div_cnt;
  logic [HW-1:0] hold_cnt;
  logic          want;
  logic          tick;

  // Strict unsigned compare: equality and threshold == 0 never press.
  assign want = ({1'b0, threshold} > rand_in);
  assign tick = enable && (div_cnt == DIV_LAST);

  // Outputs decode registered state only, so no input reaches them combinationally.
  assign press = (state == S_PRESS);
  assign busy  = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      div_cnt     <= '0;
      hold_cnt    <= '0;
      press_count <= 8'd0;
    end else begin
      if (press && (press_count != 8'hFF))
        press_count <= press_count + 8'd1;

      if (!enable) begin
        state    <= S_IDLE;
        div_cnt  <= '0;
        hold_cnt <= '0;
      end else begin
        div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
        case (state)
          S_IDLE: begin
            if (tick && want)
              state <= S_PRESS;
          end
          S_PRESS: begin
            hold_cnt <= HOLD_LOAD;
            state    <= S_HOLD;
          end
          S_HOLD: begin
            if (hold_cnt == '0)
              state <= S_IDLE;
            else
              hold_cnt <= hold_cnt - 1'b1;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cpu_player.sv
// tb/tb_cpu_player.sv - self-checking bench for cpu_player
// Default instance plus a SAMPLE_DIV=4 / HOLDOFF=1 instance sharing the stimulus.
module tb_cpu_player;

  localparam int HO = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [9:0] rand_in;
  logic [8:0] threshold;
  logic       press, busy;
  logic [7:0] press_count;
  logic       press4, busy4;
  logic [7:0] count4;

  int n_cmp = 0;
  int n_bad = 0;

  cpu_player dut (
    .clk(clk), .reset(reset), .enable(enable), .rand_in(rand_in),
    .threshold(threshold), .press(press), .busy(busy), .press_count(press_count)
  );

  cpu_player #(.WIDTH(10), .HOLDOFF(1), .SAMPLE_DIV(4)) dut4 (
    .clk(clk), .reset(reset), .enable(enable), .rand_in(rand_in),
    .threshold(threshold), .press(press4), .busy(busy4), .press_count(count4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] thr;
    logic [9:0] rnd;
    logic       exp_press;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; enable = 1'b0; threshold = '0; rand_in = '0;
    step;
    reset = 1'b0;
  endtask

  // Reference model state: outputs expected in the current cycle.
  int m_press, m_busy, m_count, free_at, run, t;

  initial begin
    vecs[0] = '{9'd0,   10'd0,    1'b0};
    vecs[1] = '{9'd511, 10'd600,  1'b0};
    vecs[2] = '{9'd511, 10'd511,  1'b0};
    vecs[3] = '{9'd511, 10'd510,  1'b1};
    vecs[4] = '{9'd511, 10'd10,   1'b1};
    vecs[5] = '{9'd1,   10'd0,    1'b1};
    vecs[6] = '{9'd5,   10'd5,    1'b0};
    vecs[7] = '{9'd5,   10'd4,    1'b1};
    vecs[8] = '{9'd0,   10'd1023, 1'b0};
    vecs[9] = '{9'd300, 10'd299,  1'b1};

    reset = 1'b1; enable = 1'b0; threshold = '0; rand_in = '0;
    step; step;
    reset = 1'b0;
    chk("reset_press", press, 0);
    chk("reset_busy", busy, 0);
    chk("reset_count", press_count, 0);

    // Single-decision vectors: one enabled tick cycle, press expected next cycle.
    for (int i = 0; i < 10; i++) begin
      do_reset;
      threshold = vecs[i].thr; rand_in = vecs[i].rnd; enable = 1'b1;
      step;
      chk("vec_press", press, int'(vecs[i].exp_press));
      chk("vec_busy", busy, int'(vecs[i].exp_press));
    end

    // threshold = 0 never presses.
    do_reset;
    enable = 1'b1;
    for (int c = 0; c < 20; c++) begin
      chk("thr0_press", press, 0);
      chk("thr0_busy", busy, 0);
      chk("thr0_count", press_count, 0);
      step;
    end

    // want held from enable rising at cycle 0.
    do_reset;
    threshold = 9'd511; rand_in = 10'd10; enable = 1'b1;
    for (int c = 0; c < 30; c++) begin
      chk("period_press", press, int'(c >= 1 && (c - 1) % 6 == 0));
      chk("period_busy", busy, int'(c >= 1 && (c - 1) % 6 < 5));
      chk("div4_press", press4, int'(c >= 4 && c % 4 == 0));
      chk("div4_busy", busy4, int'(c >= 4 && c % 4 <= 1));
      step;
    end
    chk("period_count", press_count, 5);
    chk("div4_count", count4, 7);

    // enable dropped on the 2nd HOLDOFF cycle, then re-enabled.
    do_reset;
    threshold = 9'd511; rand_in = 10'd10; enable = 1'b1;
    step;
    chk("drop_press1", press, 1);
    step;
    rand_in = 10'd1023;
    step;
    chk("drop_busy_before", busy, 1);
    enable = 1'b0; rand_in = 10'd10;
    step;
    chk("drop_busy_after", busy, 0);
    chk("drop_press_after", press, 0);
    enable = 1'b1;
    step;
    chk("reen_press", press, 1);
    for (int c = 1; c <= HO; c++) begin
      step;
      chk("reen_hold_busy", busy, 1);
      chk("reen_hold_press", press, 0);
    end
    step;
    chk("reen_idle_busy", busy, 0);
    step;
    chk("reen_next_press", press, 1);
    chk("reen_count", press_count, 2);

    // Reset for one cycle while in PRESS.
    reset = 1'b1;
    step;
    reset = 1'b0;
    chk("rst_press", press, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", press_count, 0);
    step;
    chk("rst_fresh_press", press, 1);

    // Saturation plus pulse spacing over 300+ pulses.
    begin
      int pulses, last_p, spacing_bad;
      do_reset;
      threshold = 9'd511; rand_in = 10'd10; enable = 1'b1;
      pulses = 0; last_p = -100; spacing_bad = 0;
      for (int c = 0; c < 1870; c++) begin
        chk("sat_count", press_count, (pulses > 255) ? 255 : pulses);
        if (press) begin
          if (c - last_p < HO + 1) spacing_bad++;
          last_p = c;
          pulses++;
        end
        step;
      end
      chk("sat_pulses_ge_300", int'(pulses >= 300), 1);
      chk("sat_spacing", spacing_bad, 0);
      chk("sat_final", press_count, 255);
    end

    // Randomised run against a timeline model.
    do_reset;
    m_press = 0; m_busy = 0; m_count = 0; free_at = 0; run = 0; t = 0;
    for (int k = 0; k < 3000; k++) begin
      int n_press, n_busy, tk, wnt;
      chk("rnd_press", press, m_press);
      chk("rnd_busy", busy, m_busy);
      chk("rnd_count", press_count, m_count);
      reset     = ($urandom_range(0, 99) == 0);
      enable    = ($urandom_range(0, 14) != 0);
      threshold = 9'($urandom_range(0, 511));
      rand_in   = ($urandom_range(0, 3) == 0) ? {1'b0, threshold} : 10'($urandom_range(0, 1023));
      wnt = (int'(threshold) > int'(rand_in));
      tk  = enable && (run % 1 == 0);
      if (reset) begin
        n_press = 0; n_busy = 0; m_count = 0; free_at = 0; run = 0;
      end else begin
        m_count = (m_count + m_press > 255) ? 255 : m_count + m_press;
        if (!enable) begin
          n_press = 0; n_busy = 0; free_at = 0; run = 0;
        end else begin
          n_press = (t >= free_at) && tk && wnt;
          if (n_press) free_at = t + 1 + HO + 1;
          n_busy = (t + 1 < free_at);
          run++;
        end
      end
      m_press = n_press; m_busy = n_busy;
      step;
      t++;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
